// File: rtl/spmv_fetch_pkg.sv
// Shared constants and the per-channel stream descriptor used by the fetcher.
package spmv_fetch_pkg;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_ADDR_W     = 48;
    localparam int DEF_CNT_W      = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;
    localparam int OUTS_W         = 8;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_CNT_W-1:0]  remaining;
        logic [OUTS_W-1:0]     outstanding;
    } chan_desc_t;

endpackage

// File: rtl/multi_stream_fetcher_if.sv
// Tagged memory request/response bundle between the fetcher (master) and memory (slave).
interface multi_stream_fetcher_if #(
    parameter int TAG_W  = 2,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64
);
    logic              req_mem_ld;
    logic [ADDR_W-1:0] req_mem_addr;
    logic [TAG_W-1:0]  req_mem_tag;
    logic              req_mem_stall;
    logic              rsp_mem_push;
    logic [TAG_W-1:0]  rsp_mem_tag;
    logic [DATA_W-1:0] rsp_mem_q;
    logic              rsp_mem_stall;

    modport master (
        output req_mem_ld, req_mem_addr, req_mem_tag, rsp_mem_stall,
        input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
    );

    modport slave (
        input  req_mem_ld, req_mem_addr, req_mem_tag, rsp_mem_stall,
        output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
    );
endinterface

// File: rtl/multi_stream_fetcher_stream_fifo.sv
// Show-ahead FIFO: rd_data is the head whenever count is non-zero; rd_en pops it.
module stream_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_arr [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_rd;

    assign do_rd   = rd_en && (count_reg != '0);
    assign rd_data = mem_arr[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (wr_en) mem_arr[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({wr_en, do_rd})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/multi_stream_fetcher.sv
// N-channel sequential word fetcher with round-robin tagged requests and credit-limited FIFOs.
// Define MULTI_STREAM_FETCHER_LAST_EN to add the out_last end-of-descriptor flag.
module multi_stream_fetcher
    import spmv_fetch_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int TAG_W      = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    input  logic [TAG_W-1:0]             cfg_ch,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [CNT_W-1:0]             cfg_words,
    output logic                         cfg_err,
    output logic                         busy,
    multi_stream_fetcher_if.master       mem,
    output logic [CHANNELS-1:0]          out_push,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
`ifdef MULTI_STREAM_FETCHER_LAST_EN
    output logic [CHANNELS-1:0]          out_last,
`endif
    input  logic [CHANNELS-1:0]          out_stall
);
    localparam int CNT_FW = $clog2(FIFO_DEPTH) + 1;

    logic [CHANNELS-1:0]   elig, issue_vec, wr_vec, pop_vec, cfg_acc_vec, chan_busy;
    logic [CNT_FW-1:0]     fifo_count [CHANNELS];
    logic [DATA_W-1:0]     fifo_head  [CHANNELS];
    logic [DEF_ADDR_W-1:0] chan_addr  [CHANNELS];
    logic [TAG_W-1:0]      rr_ptr_reg, grant, cand;
    logic                  any_elig, issue, cfg_err_reg;
    logic [ADDR_W-1:0]     cfg_base;

    assign cfg_base = cfg_addr & ~ADDR_W'(BYTES_PER_WORD - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : ch_g
            chan_desc_t desc_reg;
            logic       idle;

            assign idle            = (desc_reg.remaining == '0) && (desc_reg.outstanding == '0);
            // Credit: never promise more words than the FIFO can hold.
            assign elig[gi]        = (desc_reg.remaining != '0) &&
                                     ((int'(desc_reg.outstanding) + int'(fifo_count[gi])) < FIFO_DEPTH);
            assign cfg_acc_vec[gi] = cfg_valid && (cfg_ch == TAG_W'(gi)) && idle;
            assign issue_vec[gi]   = issue && (grant == TAG_W'(gi));
            // Responses to a channel with nothing outstanding are stale and dropped.
            assign wr_vec[gi]      = mem.rsp_mem_push && (mem.rsp_mem_tag == TAG_W'(gi)) &&
                                     (desc_reg.outstanding != '0);
            assign pop_vec[gi]     = (fifo_count[gi] != '0) && !out_stall[gi];
            assign chan_addr[gi]   = desc_reg.addr;
            assign chan_busy[gi]   = !idle || (fifo_count[gi] != '0);
            assign out_push[gi]    = pop_vec[gi];
            assign out_data[gi*DATA_W +: DATA_W] = (fifo_count[gi] != '0) ? fifo_head[gi] : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    desc_reg <= '0;
                end else begin
                    if (cfg_acc_vec[gi]) begin
                        desc_reg.addr      <= DEF_ADDR_W'(cfg_base);
                        desc_reg.remaining <= DEF_CNT_W'(cfg_words);
                    end else if (issue_vec[gi]) begin
                        desc_reg.addr      <= desc_reg.addr + DEF_ADDR_W'(BYTES_PER_WORD);
                        desc_reg.remaining <= desc_reg.remaining - DEF_CNT_W'(1);
                    end
                    if (issue_vec[gi] && !wr_vec[gi])
                        desc_reg.outstanding <= desc_reg.outstanding + OUTS_W'(1);
                    else if (!issue_vec[gi] && wr_vec[gi])
                        desc_reg.outstanding <= desc_reg.outstanding - OUTS_W'(1);
                end
            end

            stream_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_vec[gi]),
                .wr_data (mem.rsp_mem_q),
                .rd_en   (pop_vec[gi]),
                .rd_data (fifo_head[gi]),
                .count   (fifo_count[gi])
            );

`ifdef MULTI_STREAM_FETCHER_LAST_EN
            logic [CNT_W-1:0] deliver_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)              deliver_cnt_reg <= '0;
                else if (cfg_acc_vec[gi]) deliver_cnt_reg <= cfg_words;
                else if (pop_vec[gi])     deliver_cnt_reg <= deliver_cnt_reg - CNT_W'(1);
            end

            assign out_last[gi] = pop_vec[gi] && (deliver_cnt_reg == CNT_W'(1));
`endif
        end
    endgenerate

    // Round-robin search starting at the pointer; CHANNELS is a power of two so the index wraps.
    always_comb begin
        grant    = rr_ptr_reg;
        any_elig = 1'b0;
        cand     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = rr_ptr_reg + TAG_W'(k);
            if (!any_elig && elig[cand]) begin
                grant    = cand;
                any_elig = 1'b1;
            end
        end
    end

    assign issue             = any_elig && !mem.req_mem_stall;
    assign mem.req_mem_ld    = issue;
    assign mem.req_mem_addr  = issue ? ADDR_W'(chan_addr[grant]) : '0;
    assign mem.req_mem_tag   = issue ? grant : '0;
    assign mem.rsp_mem_stall = 1'b0;
    assign busy              = |chan_busy;
    assign cfg_err           = cfg_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg  <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            if (issue) rr_ptr_reg <= grant + TAG_W'(1);
            cfg_err_reg <= cfg_valid && !(|cfg_acc_vec);
        end
    end
endmodule

// File: tb/tb_multi_stream_fetcher.sv
// Directed self-checking bench for multi_stream_fetcher with a simple in-bench memory model.
module tb_multi_stream_fetcher;
    localparam int CH = 4, TW = 2, AW = 48, DW = 64, CW = 32, DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid;
    logic [TW-1:0]     cfg_ch;
    logic [AW-1:0]     cfg_addr;
    logic [CW-1:0]     cfg_words;
    logic              cfg_err, busy;
    logic [CH-1:0]     out_push, out_stall;
    logic [CH*DW-1:0]  out_data;
`ifdef MULTI_STREAM_FETCHER_LAST_EN
    logic [CH-1:0]     out_last;
`endif

    always #5 clk = ~clk;

    multi_stream_fetcher_if #(.TAG_W(TW), .ADDR_W(AW), .DATA_W(DW)) mem ();

    multi_stream_fetcher #(
        .CHANNELS(CH), .TAG_W(TW), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_words (cfg_words),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .mem       (mem),
        .out_push  (out_push),
        .out_data  (out_data),
`ifdef MULTI_STREAM_FETCHER_LAST_EN
        .out_last  (out_last),
`endif
        .out_stall (out_stall)
    );

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        last;
        int          cyc;
    } del_t;

    int          total = 0, bad = 0;
    int          cyc = 0, err_cnt = 0, err_cyc = -1;
    bit          auto_rsp = 1'b1;
    logic [AW-1:0] req_addr_q[$];
    logic [TW-1:0] req_tag_q[$];
    int            req_cyc_q[$];
    logic [AW-1:0] pend_addr[$];
    logic [TW-1:0] pend_tag[$];
    del_t          got_q[$];
    int            rsp_order[4] = '{2, 0, 3, 1};

    function automatic logic [63:0] mdata(input logic [AW-1:0] a);
        return 64'hDA7A_0000_0000_0000 | {16'h0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample outputs mid-cycle, return just after the next edge.
    task automatic tick();
        if (auto_rsp) begin
            if (pend_addr.size() > 0) begin
                mem.rsp_mem_push = 1'b1;
                mem.rsp_mem_tag  = pend_tag.pop_front();
                mem.rsp_mem_q    = mdata(pend_addr.pop_front());
            end else begin
                mem.rsp_mem_push = 1'b0;
                mem.rsp_mem_tag  = '0;
                mem.rsp_mem_q    = '0;
            end
        end
        @(negedge clk);
        if (mem.req_mem_ld) begin
            req_addr_q.push_back(mem.req_mem_addr);
            req_tag_q.push_back(mem.req_mem_tag);
            req_cyc_q.push_back(cyc);
            if (auto_rsp) begin
                pend_addr.push_back(mem.req_mem_addr);
                pend_tag.push_back(mem.req_mem_tag);
            end
            $display("cyc %0d req tag=%0d addr=0x%0h", cyc, mem.req_mem_tag, mem.req_mem_addr);
        end
        for (int c = 0; c < CH; c++) begin
            if (out_push[c]) begin
                del_t d;
                d.ch   = c;
                d.data = out_data[c*DW +: DW];
`ifdef MULTI_STREAM_FETCHER_LAST_EN
                d.last = out_last[c];
`else
                d.last = 1'b0;
`endif
                d.cyc  = cyc;
                got_q.push_back(d);
                $display("cyc %0d out ch=%0d data=0x%0h last=%0b", cyc, c, d.data, d.last);
            end
        end
        if (cfg_err) begin
            err_cnt++;
            err_cyc = cyc;
            $display("cyc %0d cfg_err", cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [AW-1:0] a, input int n);
        cfg_valid = 1'b1;
        cfg_ch    = TW'(ch);
        cfg_addr  = a;
        cfg_words = CW'(n);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic clear_logs();
        req_addr_q.delete();
        req_tag_q.delete();
        req_cyc_q.delete();
        got_q.delete();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_stream(input int ch, input logic [AW-1:0] base, input int n);
        int k = 0;
        foreach (got_q[i]) begin
            if (got_q[i].ch == ch) begin
                chk($sformatf("ch%0d_word%0d", ch, k), got_q[i].data, mdata(base + AW'(8 * k)));
                k++;
            end
        end
        chk($sformatf("ch%0d_count", ch), 64'(k), 64'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int n;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_words = '0;
        out_stall = '0;
        mem.req_mem_stall = 1'b0; mem.rsp_mem_push = 1'b0;
        mem.rsp_mem_tag = '0; mem.rsp_mem_q = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ld", 64'(mem.req_mem_ld), 64'd0);
        chk("rst_req_addr", 64'(mem.req_mem_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_push", 64'(out_push), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_rsp_stall", 64'(mem.rsp_mem_stall), 64'd0);
        chk("rst_out_data", out_data[63:0], 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single stream, zero-latency memory
        clear_logs();
        c0 = cyc;
        cfg(0, 48'h1000, 5);
        run_until_idle(40, "single");
        chk("single_nreq", 64'(req_addr_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("single_addr%0d", i), 64'(req_addr_q[i]), 64'h1000 + 64'(8 * i));
            chk($sformatf("single_tag%0d", i), 64'(req_tag_q[i]), 64'd0);
        end
        chk("single_first_req_cyc", 64'(req_cyc_q[0]), 64'(c0 + 1));
        chk("single_first_push_cyc", 64'(got_q[0].cyc), 64'(c0 + 3));
        chk_stream(0, 48'h1000, 5);

        // Credit limit with consumer stalled
        clear_logs();
        out_stall = 4'b0010;
        cfg(1, 48'h2000, 20);
        repeat (30) tick();
        chk("credit_nreq", 64'(req_addr_q.size()), 64'd8);
        chk("credit_busy", 64'(busy), 64'd1);
        chk("credit_nout", 64'(got_q.size()), 64'd0);
        out_stall = '0;
        run_until_idle(100, "credit");
        chk("credit_nreq_total", 64'(req_addr_q.size()), 64'd20);
        chk_stream(1, 48'h2000, 20);

        // Round-robin with a mid-run request stall
        do_reset();
        clear_logs();
        mem.req_mem_stall = 1'b1;
        for (int c = 0; c < 4; c++) cfg(c, 48'h3000 + 48'(c * 'h100), 3);
        mem.req_mem_stall = 1'b0;
        repeat (5) tick();
        chk("rr_nreq_pre", 64'(req_addr_q.size()), 64'd5);
        mem.req_mem_stall = 1'b1;
        repeat (4) tick();
        chk("rr_nreq_stalled", 64'(req_addr_q.size()), 64'd5);
        mem.req_mem_stall = 1'b0;
        run_until_idle(40, "rr");
        chk("rr_nreq", 64'(req_addr_q.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rr_tag%0d", i), 64'(req_tag_q[i]), 64'(i % 4));
            chk($sformatf("rr_addr%0d", i), 64'(req_addr_q[i]),
                64'h3000 + 64'((i % 4) * 'h100) + 64'(8 * (i / 4)));
        end
        for (int c = 0; c < 4; c++) chk_stream(c, 48'h3000 + 48'(c * 'h100), 3);

        // Out-of-order responses across tags
        clear_logs();
        auto_rsp = 1'b0;
        mem.rsp_mem_push = 1'b0;
        for (int c = 0; c < 4; c++) cfg(c, 48'h4000 + 48'(c * 'h100), 2);
        repeat (8) tick();
        chk("ooo_nreq", 64'(req_addr_q.size()), 64'd8);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
                mem.rsp_mem_push = 1'b1;
                mem.rsp_mem_tag  = TW'(rsp_order[j]);
                mem.rsp_mem_q    = mdata(48'h4000 + 48'(rsp_order[j] * 'h100) + 48'(8 * r));
                tick();
            end
        end
        mem.rsp_mem_push = 1'b0;
        run_until_idle(20, "ooo");
        chk("ooo_first_ch", 64'(got_q[0].ch), 64'd2);
        for (int c = 0; c < 4; c++) chk_stream(c, 48'h4000 + 48'(c * 'h100), 2);
        auto_rsp = 1'b1;

        // Reconfigure an active channel, then a zero-length descriptor
        clear_logs();
        err_cnt = 0;
        cfg(0, 48'h5000, 4);
        tick();
        c0 = cyc;
        cfg(0, 48'h6000, 4);
        run_until_idle(40, "recfg");
        chk("recfg_err_cnt", 64'(err_cnt), 64'd1);
        chk("recfg_err_cyc", 64'(err_cyc), 64'(c0 + 1));
        chk("recfg_nreq", 64'(req_addr_q.size()), 64'd4);
        chk_stream(0, 48'h5000, 4);
        clear_logs();
        cfg(2, 48'h9000, 0);
        repeat (4) tick();
        chk("zero_nreq", 64'(req_addr_q.size()), 64'd0);
        chk("zero_err_cnt", 64'(err_cnt), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);

        // Reset mid-stream after three issues; stale responses must be dropped
        clear_logs();
        cfg(0, 48'h7000, 10);
        n = 0;
        while (req_addr_q.size() < 3 && n < 20) begin
            tick();
            n++;
        end
        chk("midrst_nreq_before", 64'(req_addr_q.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ld", 64'(mem.req_mem_ld), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_push", 64'(out_push), 64'd0);
        chk("midrst_out_data", out_data[63:0], 64'd0);
        clear_logs();
        tick();
        rst_n = 1'b1;
        auto_rsp = 1'b0;
        mem.rsp_mem_push = 1'b1;
        mem.rsp_mem_tag  = '0;
        mem.rsp_mem_q    = mdata(48'h7018);
        tick();
        mem.rsp_mem_push = 1'b0;
        repeat (3) tick();
        auto_rsp = 1'b1;
        chk("midrst_nout", 64'(got_q.size()), 64'd0);
        chk("midrst_nreq_after", 64'(req_addr_q.size()), 64'd0);
        chk("midrst_busy_after", 64'(busy), 64'd0);

        // Clean 10-word run
        clear_logs();
        cfg(0, 48'h8000, 10);
        run_until_idle(60, "clean");
        chk_stream(0, 48'h8000, 10);
`ifdef MULTI_STREAM_FETCHER_LAST_EN
        for (int i = 0; i < got_q.size(); i++)
            chk($sformatf("last_word%0d", i), 64'(got_q[i].last), 64'(i == 9));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
